// File: rtl/div_pkg.sv
// Shared definitions for the sequential unsigned divider.
package div_pkg;

  localparam int unsigned DIV_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_u_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into the
// partial remainder and emits one quotient bit.
module div_u_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // The partial remainder is always below the divisor, so a failed trial
  // leaves a shifted value that still fits in WIDTH bits.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_u_seq.sv
// Iterative unsigned divider, one quotient bit per clock, result packed as
// {remainder, quotient} behind a start/busy/done handshake.
module div_u_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  div_state_e           state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [WIDTH-1:0]     rem_q, rem_d;
  logic [WIDTH-1:0]     quo_q, quo_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic                 dbz_q, dbz_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic [WIDTH-1:0]     step_rem;
  logic [WIDTH-1:0]     step_quo;

  div_u_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    dbz_d    = dbz_q;
    result_d = result_q;
    case (state_q)
      RUN: begin
        rem_d   = step_rem;
        quo_d   = step_quo;
        count_d = count_q + 1'b1;
        // The last iteration writes straight into the result register so
        // that result is valid in the same cycle as done.
        if (count_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          result_d = {step_rem, step_quo};
        end
      end
      default: begin
        state_d = IDLE;
        if (start) begin
          count_d = '0;
          if (divisor == '0) begin
            state_d  = DONE;
            dbz_d    = 1'b1;
            result_d = {dividend, {WIDTH{1'b1}}};
          end else begin
            state_d = RUN;
            dbz_d   = 1'b0;
            rem_d   = '0;
            quo_d   = dividend;
            dvs_d   = divisor;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      dbz_q    <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      dbz_q    <= dbz_d;
      result_q <= result_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign result      = result_q;

endmodule

// File: tb/tb_div_u_seq.sv
// Self-checking bench for div_u_seq: directed cases with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_div_u_seq;

  localparam int unsigned W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [2*W-1:0] result;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit cmp_en = 1'b0;

  div_u_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .result      (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: an accepted division yields its answer from / and %
  // after W busy cycles (immediately when dividing by zero).
  logic           exp_busy = 1'b0;
  logic           exp_done = 1'b0;
  logic           exp_dbz  = 1'b0;
  logic [2*W-1:0] exp_result = '0;
  logic [2*W-1:0] pend = '0;
  int             left = 0;

  always @(posedge clk) begin
    logic           b, d, z;
    logic [2*W-1:0] r, p;
    int             l;
    b = exp_busy; d = 1'b0; z = exp_dbz; r = exp_result; p = pend; l = left;
    if (reset) begin
      b = 1'b0; z = 1'b0; r = '0; l = 0;
    end else if (b) begin
      l = l - 1;
      if (l == 0) begin
        b = 1'b0; d = 1'b1; r = p;
      end
    end else if (start) begin
      if (divisor == 0) begin
        d = 1'b1; z = 1'b1; r = {dividend, 32'hFFFF_FFFF};
      end else begin
        z = 1'b0; b = 1'b1; l = W;
        p = {dividend % divisor, dividend / divisor};
      end
    end
    exp_busy   <= b;
    exp_done   <= d;
    exp_dbz    <= z;
    exp_result <= r;
    pend       <= p;
    left       <= l;
  end

  task automatic check(input string name, input logic [2*W-1:0] got, input logic [2*W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("busy",   {63'd0, busy},        {63'd0, exp_busy});
      check("done",   {63'd0, done},        {63'd0, exp_done});
      check("dbz",    {63'd0, div_by_zero}, {63'd0, exp_dbz});
      check("result", result,               exp_result);
    end
  end

  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 3))
      0:       return W'($urandom_range(0, 20));
      1:       return $urandom;
      2:       return 32'hFFFF_FFFF - W'($urandom_range(0, 3));
      default: return $urandom >> $urandom_range(0, 31);
    endcase
  endfunction

  // Called at a negedge while the divider can accept; returns at the negedge
  // where done is seen, with lat = cycles from start to done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] q, input logic [W-1:0] r,
                        input int lat_exp, input logic dbz_exp);
    int lat;
    dividend = a; divisor = b; start = 1'b1; lat = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      dividend = $urandom; divisor = $urandom;
      lat++;
    end while (done !== 1'b1 && lat < 100);
    check("latency", 64'(lat), 64'(lat_exp));
    check("quotient", {32'd0, result[W-1:0]}, {32'd0, q});
    check("remainder", {32'd0, result[2*W-1:W]}, {32'd0, r});
    check("div_by_zero", {63'd0, div_by_zero}, {63'd0, dbz_exp});
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    cmp_en = 1'b1;
    check("rst_busy",   {63'd0, busy},        64'd0);
    check("rst_done",   {63'd0, done},        64'd0);
    check("rst_dbz",    {63'd0, div_by_zero}, 64'd0);
    check("rst_result", result,               64'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
    @(negedge clk);
    run_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, 1'b0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 33, 1'b0);
    run_op(32'd5, 32'd9, 32'd0, 32'd5, 33, 1'b0);
    run_op(32'd0, 32'd3, 32'd0, 32'd0, 33, 1'b0);
    run_op(32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1, 1'b1);
    run_op(32'd10, 32'd3, 32'd3, 32'd1, 33, 1'b0);

    // Start while busy is ignored; start in the DONE cycle is accepted.
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    dividend = 32'd50; divisor = 32'd5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    check("ignored_wait", {63'd0, done}, 64'd1);
    check("ignored_q", {32'd0, result[W-1:0]},   64'd14);
    check("ignored_r", {32'd0, result[2*W-1:W]}, 64'd2);
    run_op(32'd50, 32'd5, 32'd10, 32'd0, 33, 1'b0);

    // Reset in the middle of a run aborts without a done pulse.
    @(negedge clk);
    dividend = 32'd100; divisor = 32'd7; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (14) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    check("abort_busy",   {63'd0, busy}, 64'd0);
    check("abort_done",   {63'd0, done}, 64'd0);
    check("abort_result", result,        64'd0);
    n = 0;
    repeat (40) begin @(negedge clk); if (done === 1'b1) n++; end
    check("abort_no_done", 64'(n), 64'd0);
    run_op(32'd81, 32'd9, 32'd9, 32'd0, 33, 1'b0);

    // Randomized traffic: starts at any time, operands wiggling, rare resets.
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      start    = ($urandom_range(0, 2) == 0);
      dividend = rnd();
      divisor  = ($urandom_range(0, 7) == 0) ? '0 : rnd();
      reset    = ($urandom_range(0, 599) == 0);
    end
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
